// File: rtl/lsu_mem_if.sv
// Core-side request/response channels and the physical-memory port of the
// LSU, bundled as one interface. The master modport is the LSU itself; the
// slave modport is the environment (core execute stage plus memory).
//
// Handshake rules for both req and resp channels: a transfer happens on a
// rising clk edge where valid and ready are both high; once valid is raised
// the sender holds it and its payload stable until that transfer, and ready
// may be raised or dropped freely while valid is low.
interface lsu_mem_if #(
    parameter int TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_wen;
    logic [63:0]      req_addr;
    logic [63:0]      req_wdata;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_rdata;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    logic [63:0]      mem_raddr;
    logic             mem_read;
    logic [63:0]      mem_waddr;
    logic [63:0]      mem_wdata;
    logic [7:0]       mem_wmask;
    logic             mem_write;
    logic [63:0]      mem_rdata;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, req_tag,
        output req_ready,
        output resp_valid, resp_rdata, resp_tag, resp_err,
        input  resp_ready,
        output mem_raddr, mem_read, mem_waddr, mem_wdata, mem_wmask, mem_write,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, req_tag,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_tag, resp_err,
        output resp_ready,
        input  mem_raddr, mem_read, mem_waddr, mem_wdata, mem_wmask, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one load or store from the core, turns it into
// an 8-byte-aligned memory read or write, and returns the lane-extracted,
// sign/zero-extended result on the response channel. Misaligned requests
// complete with resp_err and never touch memory.
//
// Optional build macro LSU_TRACE_EN: adds a free-running cycle counter and
// prints one line per completed transaction.
module lsu_mem_initiator #(
    parameter int RD_LATENCY = 1,
    parameter int TAG_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    lsu_mem_if.master  bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             wen_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [3:0]       cnt_q;
    logic [63:0]      result_q;

    logic             misaligned;
    logic             accept;
    logic [7:0]       lane_mask;
    logic [63:0]      load_data;

    assign dbg_state = state_q;
    assign accept    = (state_q == S_IDLE) && bus.req_valid;

    // Shift the addressed lane down to bit 0, truncate to the access size and
    // extend; a dword has no bits to extend so the unsigned flag is moot.
    function automatic logic [63:0] extract(input logic [63:0] raw,
                                            input logic [2:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
        logic [63:0] shifted;
        logic [63:0] res;
        shifted = raw >> {off, 3'b000};
        case (size)
            2'd0:    res = {{56{~uns & shifted[7]}},  shifted[7:0]};
            2'd1:    res = {{48{~uns & shifted[15]}}, shifted[15:0]};
            2'd2:    res = {{32{~uns & shifted[31]}}, shifted[31:0]};
            default: res = shifted;
        endcase
        return res;
    endfunction

    // Alignment test on the incoming request: addr mod 2^size must be zero.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = |bus.req_addr[2:0];
        endcase
    end

    // Byte-enable pattern for the latched access, placed at its lane offset.
    always_comb begin
        lane_mask = 8'h00;
        case (size_q)
            2'd0:    lane_mask = 8'h01 << addr_q[2:0];
            2'd1:    lane_mask = 8'h03 << addr_q[2:0];
            2'd2:    lane_mask = 8'h0F << addr_q[2:0];
            default: lane_mask = 8'hFF << addr_q[2:0];
        endcase
    end

    assign load_data = extract(bus.mem_rdata, addr_q[2:0], size_q, uns_q);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all bus outputs; everything idles at zero by default.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 64'd0;
        bus.resp_tag   = '0;
        bus.resp_err   = 1'b0;
        bus.mem_raddr  = 64'd0;
        bus.mem_read   = 1'b0;
        bus.mem_waddr  = 64'd0;
        bus.mem_wdata  = 64'd0;
        bus.mem_wmask  = 8'h00;
        bus.mem_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned) begin
                        state_d = S_RESP;
                    end else if (bus.req_wen) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                bus.mem_read  = 1'b1;
                bus.mem_raddr = {addr_q[63:3], 3'b000};
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_waddr = {addr_q[63:3], 3'b000};
                bus.mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
                bus.mem_wmask = lane_mask;
                state_d       = S_RESP;
            end
            default: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = result_q;
                bus.resp_tag   = tag_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Request latch, read-latency counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            wen_q    <= 1'b0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 4'd0;
            result_q <= 64'd0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            size_q   <= bus.req_size;
            uns_q    <= bus.req_unsigned;
            wen_q    <= bus.req_wen;
            tag_q    <= bus.req_tag;
            err_q    <= misaligned;
            cnt_q    <= 4'(RD_LATENCY - 1);
            result_q <= 64'd0;
        end else if (state_q == S_RD) begin
            if (cnt_q == 4'd0) begin
                result_q <= load_data;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

`ifdef LSU_TRACE_EN
    logic [63:0] cycle_q;
    logic [7:0]  kind;
    logic [63:0] trace_data;
    logic [7:0]  trace_mask;

    assign kind       = err_q ? "E" : (wen_q ? "S" : "L");
    assign trace_data = wen_q ? wdata_q : result_q;
    assign trace_mask = (wen_q && !err_q) ? lane_mask : 8'h00;

    // Free-running cycle count used to timestamp trace lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= 64'd0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    // One line per transaction, printed on its response handshake.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && bus.resp_ready) begin
            $display("lsu cyc=%0d %c addr=%h size=%0d data=%h wmask=%h",
                     cycle_q, kind, addr_q, size_q, trace_data, trace_mask);
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator. Two instances share one stimulus stream: the
// main one with a 3-cycle read latency and a second with latency 1, so both
// the multi-cycle read and the minimum one-cycle read residency are covered.
module tb_lsu_mem_initiator;

    localparam int LAT   = 3;
    localparam int TAG_W = 5;

    typedef struct {
        logic             wen;
        logic [63:0]      addr;
        logic [63:0]      wdata;
        logic [1:0]       size;
        logic             uns;
        logic [TAG_W-1:0] tag;
        logic [63:0]      mem;
        logic [63:0]      exp_rdata;
        logic             exp_err;
        logic [63:0]      exp_waddr;
        logic [63:0]      exp_wdata;
        logic [7:0]       exp_wmask;
        int               hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st_a;
    logic [1:0] st_b;

    int checks = 0;
    int errors = 0;

    // {err, tag, rdata} per response; {waddr, wdata, wmask} per write strobe
    logic [69:0]  exp_q[$];
    logic [135:0] exp_wr_q[$];

    vec_t vecs[13];

    always #5 clk = ~clk;

    lsu_mem_if #(.TAG_W(TAG_W)) a ();
    lsu_mem_if #(.TAG_W(TAG_W)) b ();

    assign b.req_valid    = a.req_valid;
    assign b.req_wen      = a.req_wen;
    assign b.req_addr     = a.req_addr;
    assign b.req_wdata    = a.req_wdata;
    assign b.req_size     = a.req_size;
    assign b.req_unsigned = a.req_unsigned;
    assign b.req_tag      = a.req_tag;
    assign b.resp_ready   = a.resp_ready;
    assign b.mem_rdata    = a.mem_rdata;

    lsu_mem_initiator #(.RD_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (a),
        .dbg_state (st_a)
    );

    lsu_mem_initiator #(.RD_LATENCY(1), .TAG_W(TAG_W)) dut_lat1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b),
        .dbg_state (st_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Write-strobe scoreboard plus idle-bus checks on the main instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (a.mem_write) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'(a.mem_write), 64'd0);
                end else begin
                    logic [135:0] e;
                    e = exp_wr_q.pop_front();
                    check("mem_waddr", a.mem_waddr, e[135:72]);
                    check("mem_wdata", a.mem_wdata, e[71:8]);
                    check("mem_wmask", 64'(a.mem_wmask), 64'(e[7:0]));
                end
            end else begin
                check("idle_wbus", 64'(|{a.mem_waddr, a.mem_wdata, a.mem_wmask}), 64'd0);
            end
            if (!a.mem_read) begin
                check("idle_raddr", a.mem_raddr, 64'd0);
            end
        end
    end

    task automatic drive_req(input vec_t v);
        a.req_wen      = v.wen;
        a.req_addr     = v.addr;
        a.req_wdata    = v.wdata;
        a.req_size     = v.size;
        a.req_unsigned = v.uns;
        a.req_tag      = v.tag;
        a.mem_rdata    = v.mem;
        a.req_valid    = 1'b1;
    endtask

    // While busy keep req_valid high with junk fields: the DUT must ignore them.
    task automatic drive_junk();
        a.req_wen      = 1'($urandom_range(0, 1));
        a.req_addr     = {32'($urandom), 32'($urandom)};
        a.req_wdata    = {32'($urandom), 32'($urandom)};
        a.req_size     = 2'($urandom_range(0, 3));
        a.req_unsigned = 1'($urandom_range(0, 1));
        a.req_tag      = TAG_W'($urandom_range(0, 31));
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!a.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(a.req_ready), 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, lat_b, rd_n, rd_b, wr_n, exp_lat;
        logic [69:0]      e;
        logic [63:0]      held_rdata;
        logic [TAG_W-1:0] held_tag;
        wait_ready($sformatf("v%0d_ready", idx));
        exp_q.push_back({v.exp_err, v.tag, v.exp_rdata});
        if (v.wen && !v.exp_err) exp_wr_q.push_back({v.exp_waddr, v.exp_wdata, v.exp_wmask});
        drive_req(v);
        @(posedge clk);
        #1;
        drive_junk();
        lat = 0; lat_b = 0; rd_n = 0; rd_b = 0; wr_n = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (a.mem_read) rd_n++;
            if (b.mem_read) rd_b++;
            if (a.mem_write) wr_n++;
            if (b.resp_valid && lat_b == 0) lat_b = lat;
            if (a.resp_valid) break;
        end
        exp_lat = v.exp_err ? 1 : (v.wen ? 2 : LAT + 1);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(exp_lat));
        check($sformatf("v%0d_latency_lat1", idx), 64'(lat_b), 64'(v.exp_err ? 1 : 2));
        check($sformatf("v%0d_read_cycles", idx), 64'(rd_n), 64'((v.wen || v.exp_err) ? 0 : LAT));
        check($sformatf("v%0d_read_cycles_lat1", idx), 64'(rd_b), 64'((v.wen || v.exp_err) ? 0 : 1));
        check($sformatf("v%0d_write_cycles", idx), 64'(wr_n), 64'((v.wen && !v.exp_err) ? 1 : 0));
        if (exp_q.size() == 0) begin
            check($sformatf("v%0d_resp_expected", idx), 64'(a.resp_valid), 64'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_rdata", idx), a.resp_rdata, e[63:0]);
            check($sformatf("v%0d_tag", idx), 64'(a.resp_tag), 64'(e[68:64]));
            check($sformatf("v%0d_err", idx), 64'(a.resp_err), 64'(e[69]));
            check($sformatf("v%0d_rdata_lat1", idx), b.resp_rdata, e[63:0]);
            check($sformatf("v%0d_tag_lat1", idx), 64'(b.resp_tag), 64'(e[68:64]));
            check($sformatf("v%0d_err_lat1", idx), 64'(b.resp_err), 64'(e[69]));
        end
        held_rdata = a.resp_rdata;
        held_tag   = a.resp_tag;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("v%0d_hold%0d_valid", idx, h), 64'(a.resp_valid), 64'd1);
            check($sformatf("v%0d_hold%0d_rdata", idx, h), a.resp_rdata, held_rdata);
            check($sformatf("v%0d_hold%0d_tag", idx, h), 64'(a.resp_tag), 64'(held_tag));
            check($sformatf("v%0d_hold%0d_req_ready", idx, h), 64'(a.req_ready), 64'd0);
        end
        a.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        a.resp_ready = 1'b0;
        a.req_valid  = 1'b0;
        check($sformatf("v%0d_idle_ready", idx), 64'(a.req_ready), 64'd1);
        check($sformatf("v%0d_idle_resp", idx), 64'(a.resp_valid), 64'd0);
        check($sformatf("v%0d_idle_state", idx), 64'(st_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //           wen   addr                  wdata                  sz    uns   tag    mem                    exp_rdata              err   waddr                  wdata                  mask   hold
        vecs[0]  = '{1'b1, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 5'd1,  64'h0,                 64'h0,                 1'b0, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0};
        vecs[1]  = '{1'b1, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 5'd2,  64'h0,                 64'h0,                 1'b0, 64'h0000_0000_8000_0000, 64'h0000_AB00_0000_0000, 8'h20, 1};
        vecs[2]  = '{1'b0, 64'h0000_0000_8000_0002, 64'h0,                 2'd1, 1'b0, 5'd3,  64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h0, 64'h0, 8'h00, 0};
        vecs[3]  = '{1'b0, 64'h0000_0000_8000_0002, 64'h0,                 2'd1, 1'b1, 5'd4,  64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001, 1'b0, 64'h0, 64'h0, 8'h00, 2};
        vecs[4]  = '{1'b0, 64'h0000_0000_8000_0006, 64'h0,                 2'd2, 1'b0, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b1, 64'h0, 64'h0, 8'h00, 1};
        vecs[5]  = '{1'b0, 64'h0000_0000_8000_0007, 64'h0,                 2'd0, 1'b0, 5'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 64'h0, 64'h0, 8'h00, 0};
        vecs[6]  = '{1'b0, 64'h0000_0000_8000_0004, 64'h0,                 2'd2, 1'b1, 5'd7,  64'hDEAD_BEEF_1234_5678, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 64'h0, 8'h00, 0};
        vecs[7]  = '{1'b0, 64'h0000_0000_8000_0004, 64'h0,                 2'd2, 1'b0, 5'd8,  64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 64'h0, 64'h0, 8'h00, 1};
        vecs[8]  = '{1'b0, 64'h0000_0000_8000_0010, 64'h0,                 2'd3, 1'b0, 5'd9,  64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211, 1'b0, 64'h0, 64'h0, 8'h00, 4};
        vecs[9]  = '{1'b1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 5'd10, 64'h0,                 64'h0,                 1'b0, 64'h0000_0000_8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 0};
        vecs[10] = '{1'b1, 64'h0000_0000_8000_0004, 64'h1234_5678_9ABC_DEF0, 2'd3, 1'b0, 5'd11, 64'h0,                 64'h0,                 1'b1, 64'h0, 64'h0, 8'h00, 2};
        vecs[11] = '{1'b1, 64'h0000_0000_8000_000C, 64'h0000_0000_CAFE_F00D, 2'd2, 1'b0, 5'd12, 64'h0,                 64'h0,                 1'b0, 64'h0000_0000_8000_0008, 64'hCAFE_F00D_0000_0000, 8'hF0, 0};
        vecs[12] = '{1'b0, 64'h0000_0000_8000_0003, 64'h0,                 2'd0, 1'b1, 5'd13, 64'h0000_0000_A500_0000, 64'h0000_0000_0000_00A5, 1'b0, 64'h0, 64'h0, 8'h00, 3};

        // clock/reset
        a.req_valid    = 1'b0;
        a.req_wen      = 1'b0;
        a.req_addr     = 64'd0;
        a.req_wdata    = 64'd0;
        a.req_size     = 2'd0;
        a.req_unsigned = 1'b0;
        a.req_tag      = '0;
        a.resp_ready   = 1'b0;
        a.mem_rdata    = 64'd0;
        rst            = 1'b1;
        #1;
        check("rst_req_ready", 64'(a.req_ready), 64'd1);
        check("rst_resp_valid", 64'(a.resp_valid), 64'd0);
        check("rst_resp_err", 64'(a.resp_err), 64'd0);
        check("rst_mem_strobes", 64'({a.mem_read, a.mem_write}), 64'd0);
        check("rst_state", 64'(st_a), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during the second read cycle of a dword load.
        wait_ready("rmid_ready");
        v = vecs[8];
        v.tag = 5'd21;
        drive_req(v);
        @(posedge clk);
        #1;
        drive_junk();
        @(negedge clk);
        check("rmid_rd1_read", 64'(a.mem_read), 64'd1);
        @(posedge clk);
        #1;
        check("rmid_rd2_read", 64'(a.mem_read), 64'd1);
        rst = 1'b1;
        #1;
        check("rmid_read_dropped", 64'(a.mem_read), 64'd0);
        check("rmid_resp_valid", 64'(a.resp_valid), 64'd0);
        check("rmid_resp_err", 64'(a.resp_err), 64'd0);
        check("rmid_lat1_resp_dropped", 64'(b.resp_valid), 64'd0);
        a.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rmid_req_ready", 64'(a.req_ready), 64'd1);
        check("rmid_state", 64'(st_a), 64'd0);
        run_vec(13, vecs[6]);

        @(negedge clk);
        check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("write_queue_empty", 64'(exp_wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
